// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// baud divider helper used by both the rx and tx paths.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_ERR,
    ST_BREAK,
    ST_WAITHI
  } rxStateT;

  // Rounded clock cycles per oversample tick.
  function automatic int baud_div(input int clock, input int baud, input int os);
    return (clock + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable so
// the tick phase can be aligned to an incoming start edge.
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (reload || count == CW'(DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = !reload && (count == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-vote sampling, glitch-filtered start,
// optional parity, 1 or 2 stop bits and line-break detection.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rx,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParErr,
  output logic                 rxBreak,
  output logic [DATA_BITS-1:0] out
);

  localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_S0  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_MID = PW'(OVERSAMPLE / 2 + 1);

  rxStateT              state;
  logic                 rxSync1, rxSync2, rxPrev;
  logic [PW-1:0]        phase, phaseNext;
  logic                 sampleA, sampleB;
  logic [DATA_BITS-1:0] shiftReg;
  logic [3:0]           bitCnt;
  logic                 stopCnt;
  logic                 parFail;
  logic                 tick, reloadTick, startEdge, midBit, vote, parCalc, parBad;

  // Tick phase restarts at each start edge and whenever WAITHI sees the line low.
  assign startEdge  = rxEn && rxPrev && !rxSync2;
  assign reloadTick = (state == ST_IDLE && startEdge) || (state == ST_WAITHI && !rxSync2) ||
                      state == ST_ERR || state == ST_BREAK;
  assign phaseNext  = phase + PW'(1);
  assign midBit     = tick && (phaseNext == PH_MID);
  assign vote       = (sampleA & sampleB) | (sampleA & rxSync2) | (sampleB & rxSync2);
  assign parCalc    = (^shiftReg) ^ vote;
  assign parBad     = (PARITY == PARITY_ODD) ? !parCalc : parCalc;

  uart_baud_tick #(.DIV(DIV)) baudTick (
    .clk    (clk),
    .reset  (reset),
    .reload (reloadTick),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= rx;
      rxSync2 <= rxSync1;
      rxPrev  <= rxSync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      phase    <= '0;
      sampleA  <= 1'b1;
      sampleB  <= 1'b1;
      shiftReg <= '0;
      bitCnt   <= '0;
      stopCnt  <= 1'b0;
      parFail  <= 1'b0;
      rxBusy   <= 1'b0;
      rxDone   <= 1'b0;
      rxErr    <= 1'b0;
      rxParErr <= 1'b0;
      rxBreak  <= 1'b0;
      out      <= '0;
    end else begin
      rxDone   <= 1'b0;
      rxErr    <= 1'b0;
      rxParErr <= 1'b0;
      if (tick) phase <= phaseNext;
      if (tick && phaseNext == PH_S0) sampleA <= rxSync2;
      if (tick && phaseNext == PH_S1) sampleB <= rxSync2;

      if (!rxEn) begin
        state   <= ST_IDLE;
        rxBusy  <= 1'b0;
        rxBreak <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (startEdge) begin
              state <= ST_START;
              phase <= '0;
            end
          end
          ST_START: begin
            if (midBit) begin
              if (!vote) begin
                state  <= ST_DATA;
                rxBusy <= 1'b1;
                bitCnt <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            if (midBit) begin
              shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
              bitCnt   <= bitCnt + 4'd1;
              stopCnt  <= 1'b0;
              parFail  <= 1'b0;
              if (bitCnt == 4'(DATA_BITS - 1))
                state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            if (midBit) begin
              parFail <= parBad;
              state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (midBit) begin
              if (!vote) begin
                rxBusy <= 1'b0;
                rxErr  <= 1'b1;
                // All-zero data with a low first stop bit is a held-low line, not a bad frame.
                if (!stopCnt && shiftReg == '0 && !parFail) begin
                  state   <= ST_BREAK;
                  rxBreak <= 1'b1;
                end else begin
                  state    <= ST_ERR;
                  rxParErr <= parFail;
                end
              end else if (stopCnt || STOP_BITS == 1) begin
                rxBusy <= 1'b0;
                if (parFail) begin
                  state    <= ST_ERR;
                  rxErr    <= 1'b1;
                  rxParErr <= 1'b1;
                end else begin
                  state  <= ST_DONE;
                  rxDone <= 1'b1;
                  out    <= shiftReg;
                end
              end else begin
                stopCnt <= 1'b1;
              end
            end
          end
          ST_DONE:  state <= ST_IDLE;
          ST_ERR:   state <= ST_WAITHI;
          ST_BREAK: state <= ST_WAITHI;
          ST_WAITHI: begin
            if (!rxSync2) begin
              phase <= '0;
            end else if (tick && phaseNext == '0) begin
              state   <= ST_IDLE;
              rxBreak <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance
// driven with directed and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CLK_HZ = 1536000;
  localparam int BAUD   = 9600;
  localparam int BIT    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxEn = 1'b1;
  logic rxA = 1'b1;
  logic rxE = 1'b1;

  logic       busyA, doneA, errA, parA, brkA;
  logic [7:0] outA;
  logic       busyE, doneE, errE, parE, brkE;
  logic [7:0] outE;

  int errors = 0;
  int checks = 0;
  int nDoneA = 0, nErrA = 0, nBusyA = 0;
  int nDoneE = 0, nErrE = 0, nParE = 0;
  int nBoth = 0;
  logic [7:0] expOutA = 8'h00;
  logic [7:0] expOutE = 8'h00;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rx(rxA),
    .rxBusy(busyA), .rxDone(doneA), .rxErr(errA), .rxParErr(parA),
    .rxBreak(brkA), .out(outA)
  );

  uart_rx_cfg #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutE (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rx(rxE),
    .rxBusy(busyE), .rxDone(doneE), .rxErr(errE), .rxParErr(parE),
    .rxBreak(brkE), .out(outE)
  );

  always @(negedge clk) begin
    if (doneA) nDoneA++;
    if (errA) nErrA++;
    if (busyA) nBusyA++;
    if (doneE) nDoneE++;
    if (errE) nErrE++;
    if (parE) nParE++;
    if ((doneA && errA) || (doneE && errE)) nBoth++;
  end

  // Parity bit a transmitter appends: even makes the total count of ones even.
  function automatic logic parityBit(input logic [7:0] d, input int mode);
    int ones;
    ones = $countones(d);
    if (mode == 2) return logic'(ones % 2);
    return logic'((ones + 1) % 2);
  endfunction

  task automatic driveLevel(input int sel, input logic lvl, input int clks);
    @(negedge clk);
    if (sel == 0) rxA = lvl; else rxE = lvl;
    repeat (clks - 1) @(negedge clk);
  endtask

  task automatic sendFrame(input int sel, input logic [7:0] data, input int parMode,
                           input logic parFlip, input logic stopLvl, input int period,
                           input int gapBits);
    driveLevel(sel, 1'b0, period);
    for (int i = 0; i < 8; i++) driveLevel(sel, data[i], period);
    if (parMode != 0) driveLevel(sel, parityBit(data, parMode) ^ parFlip, period);
    driveLevel(sel, stopLvl, period);
    if (gapBits > 0) driveLevel(sel, 1'b1, gapBits * BIT);
    $display("frame dut%0d data=%02h parMode=%0d flip=%0d stop=%0d period=%0d",
             sel, data, parMode, parFlip, stopLvl, period);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busyA, doneA, errA, parA, brkA, outA} !== 13'h0) begin
      errors++; $display("FAIL reset_a_in: got %h expected 0", {busyA, doneA, errA, parA, brkA, outA});
    end
    checks++;
    if ({busyE, doneE, errE, parE, brkE, outE} !== 13'h0) begin
      errors++; $display("FAIL reset_e_in: got %h expected 0", {busyE, doneE, errE, parE, brkE, outE});
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({busyA, doneA, errA, parA, brkA, outA} !== 13'h0) begin
      errors++; $display("FAIL reset_a_after: got %h expected 0", {busyA, doneA, errA, parA, brkA, outA});
    end
    checks++;
    if ({busyE, doneE, errE, parE, brkE, outE} !== 13'h0) begin
      errors++; $display("FAIL reset_e_after: got %h expected 0", {busyE, doneE, errE, parE, brkE, outE});
    end
  endtask

  task automatic test_tolerance();
    int d0, e0;
    d0 = nDoneA; e0 = nErrA;
    sendFrame(0, 8'h35, 0, 1'b0, 1'b1, BIT * 103 / 100 + 1, 2);
    expOutA = 8'h35;
    checks++;
    if (nDoneA - d0 != 1) begin errors++; $display("FAIL tol_done: got %0d expected 1", nDoneA - d0); end
    checks++;
    if (nErrA - e0 != 0) begin errors++; $display("FAIL tol_err: got %0d expected 0", nErrA - e0); end
    checks++;
    if (outA !== expOutA) begin errors++; $display("FAIL tol_out: got %h expected %h", outA, expOutA); end
  endtask

  task automatic test_framing();
    int d0, e0;
    d0 = nDoneA; e0 = nErrA;
    sendFrame(0, 8'h5C, 0, 1'b0, 1'b0, BIT, 2);
    checks++;
    if (nErrA - e0 != 1) begin errors++; $display("FAIL frm_err: got %0d expected 1", nErrA - e0); end
    checks++;
    if (nDoneA - d0 != 0) begin errors++; $display("FAIL frm_done: got %0d expected 0", nDoneA - d0); end
    checks++;
    if (outA !== expOutA) begin errors++; $display("FAIL frm_out_held: got %h expected %h", outA, expOutA); end
    sendFrame(0, 8'hA5, 0, 1'b0, 1'b1, BIT, 2);
    expOutA = 8'hA5;
    checks++;
    if (nDoneA - d0 != 1) begin errors++; $display("FAIL frm_recover_done: got %0d expected 1", nDoneA - d0); end
    checks++;
    if (outA !== expOutA) begin errors++; $display("FAIL frm_recover_out: got %h expected %h", outA, expOutA); end
  endtask

  task automatic test_parity();
    int d0, e0, p0;
    d0 = nDoneE; e0 = nErrE; p0 = nParE;
    sendFrame(1, 8'h35, 2, 1'b1, 1'b1, BIT, 2);
    checks++;
    if (nErrE - e0 != 1) begin errors++; $display("FAIL par_err: got %0d expected 1", nErrE - e0); end
    checks++;
    if (nParE - p0 != 1) begin errors++; $display("FAIL par_parerr: got %0d expected 1", nParE - p0); end
    checks++;
    if (nDoneE - d0 != 0) begin errors++; $display("FAIL par_done: got %0d expected 0", nDoneE - d0); end
    checks++;
    if (outE !== expOutE) begin errors++; $display("FAIL par_out_held: got %h expected %h", outE, expOutE); end
    sendFrame(1, 8'h35, 2, 1'b0, 1'b1, BIT, 2);
    expOutE = 8'h35;
    checks++;
    if (nDoneE - d0 != 1) begin errors++; $display("FAIL par_good_done: got %0d expected 1", nDoneE - d0); end
    checks++;
    if (outE !== expOutE) begin errors++; $display("FAIL par_good_out: got %h expected %h", outE, expOutE); end
  endtask

  task automatic test_glitch();
    int d0, e0, b0;
    d0 = nDoneA; e0 = nErrA; b0 = nBusyA;
    driveLevel(0, 1'b0, BIT * 4 / 10);
    driveLevel(0, 1'b1, 2 * BIT);
    $display("glitch dut0 low=%0d clks", BIT * 4 / 10);
    checks++;
    if (nBusyA - b0 != 0) begin errors++; $display("FAIL glitch_busy: got %0d cycles expected 0", nBusyA - b0); end
    checks++;
    if ((nDoneA - d0) + (nErrA - e0) != 0) begin
      errors++; $display("FAIL glitch_pulses: got %0d expected 0", (nDoneA - d0) + (nErrA - e0));
    end
    sendFrame(0, 8'h00, 0, 1'b0, 1'b1, BIT, 2);
    expOutA = 8'h00;
    checks++;
    if (nDoneA - d0 != 1) begin errors++; $display("FAIL glitch_next_done: got %0d expected 1", nDoneA - d0); end
    checks++;
    if (outA !== expOutA) begin errors++; $display("FAIL glitch_next_out: got %h expected %h", outA, expOutA); end
  endtask

  task automatic test_break();
    int d0, e0;
    d0 = nDoneA; e0 = nErrA;
    driveLevel(0, 1'b0, 20 * BIT);
    $display("break dut0 low=%0d clks", 20 * BIT);
    checks++;
    if (brkA !== 1'b1) begin errors++; $display("FAIL brk_level_low: got %b expected 1", brkA); end
    checks++;
    if (nErrA - e0 != 1) begin errors++; $display("FAIL brk_err_once: got %0d expected 1", nErrA - e0); end
    driveLevel(0, 1'b1, 100);
    checks++;
    if (brkA !== 1'b1) begin errors++; $display("FAIL brk_hold: got %b expected 1", brkA); end
    driveLevel(0, 1'b1, 100);
    checks++;
    if (brkA !== 1'b0) begin errors++; $display("FAIL brk_clear: got %b expected 0", brkA); end
    checks++;
    if (nDoneA - d0 != 0) begin errors++; $display("FAIL brk_done: got %0d expected 0", nDoneA - d0); end
    driveLevel(0, 1'b1, BIT);
  endtask

  task automatic test_enable();
    int d0, e0, b0;
    logic [7:0] data;
    data = 8'hB6;
    d0 = nDoneA; e0 = nErrA;
    driveLevel(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) driveLevel(0, data[i], BIT);
    driveLevel(0, data[4], BIT / 2);
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("FAIL en_busy_before: got %b expected 1", busyA); end
    rxEn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busyA !== 1'b0) begin errors++; $display("FAIL en_busy_drop: got %b expected 0", busyA); end
    driveLevel(0, data[4], BIT / 2);
    for (int i = 5; i < 8; i++) driveLevel(0, data[i], BIT);
    driveLevel(0, 1'b1, 3 * BIT);
    rxEn = 1'b1;
    $display("enable drop dut0 data=%02h at bit 4", data);
    checks++;
    if ((nDoneA - d0) + (nErrA - e0) != 0) begin
      errors++; $display("FAIL en_pulses: got %0d expected 0", (nDoneA - d0) + (nErrA - e0));
    end
    checks++;
    if (outA !== expOutA) begin errors++; $display("FAIL en_out_held: got %h expected %h", outA, expOutA); end
    // Line falls while disabled; enabling with the line already low must not start a frame.
    b0 = nBusyA; e0 = nErrA;
    rxEn = 1'b0;
    driveLevel(0, 1'b0, BIT);
    rxEn = 1'b1;
    driveLevel(0, 1'b0, 2 * BIT);
    driveLevel(0, 1'b1, 2 * BIT);
    $display("enable rise with line low dut0");
    checks++;
    if ((nBusyA - b0) + (nErrA - e0) != 0) begin
      errors++; $display("FAIL en_rise_low: got %0d expected 0", (nBusyA - b0) + (nErrA - e0));
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = nDoneA;
    sendFrame(0, 8'h12, 0, 1'b0, 1'b1, BIT, 0);
    checks++;
    if (outA !== 8'h12) begin errors++; $display("FAIL b2b_first_out: got %h expected 12", outA); end
    sendFrame(0, 8'hE7, 0, 1'b0, 1'b1, BIT, 2);
    expOutA = 8'hE7;
    checks++;
    if (nDoneA - d0 != 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", nDoneA - d0); end
    checks++;
    if (outA !== expOutA) begin errors++; $display("FAIL b2b_out: got %h expected %h", outA, expOutA); end
  endtask

  task automatic test_random();
    int d0, e0, p0, per, expDone, expErr, expPar;
    logic [7:0] d;
    logic flip, stop;
    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom_range(0, 255));
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      per  = $urandom_range(BIT * 97 / 100, BIT * 103 / 100 + 1);
      d0 = nDoneE; e0 = nErrE; p0 = nParE;
      sendFrame(1, d, 2, flip, stop, per, 3);
      expDone = (stop && !flip) ? 1 : 0;
      expErr  = 1 - expDone;
      expPar  = flip ? 1 : 0;
      if (expDone == 1) expOutE = d;
      checks++;
      if (nDoneE - d0 != expDone) begin errors++; $display("FAIL rnd%0d_done: got %0d expected %0d", k, nDoneE - d0, expDone); end
      checks++;
      if (nErrE - e0 != expErr) begin errors++; $display("FAIL rnd%0d_err: got %0d expected %0d", k, nErrE - e0, expErr); end
      checks++;
      if (nParE - p0 != expPar) begin errors++; $display("FAIL rnd%0d_parerr: got %0d expected %0d", k, nParE - p0, expPar); end
      checks++;
      if (outE !== expOutE) begin errors++; $display("FAIL rnd%0d_out: got %h expected %h", k, outE, expOutE); end
    end
  endtask

  task automatic test_reset_mid();
    sendFrame(0, 8'hC3, 0, 1'b0, 1'b1, BIT, 2);
    expOutA = 8'hC3;
    checks++;
    if (outA !== expOutA) begin errors++; $display("FAIL rstmid_pre_out: got %h expected %h", outA, expOutA); end
    driveLevel(0, 1'b0, BIT);
    for (int i = 0; i < 3; i++) driveLevel(0, 1'b1, BIT);
    checks++;
    if (busyA !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b expected 1", busyA); end
    #2 reset = 1'b1;
    #1;
    $display("reset asserted mid-frame dut0");
    checks++;
    if ({busyA, doneA, errA, parA, brkA, outA} !== 13'h0) begin
      errors++; $display("FAIL rstmid_a: got %h expected 0", {busyA, doneA, errA, parA, brkA, outA});
    end
    checks++;
    if ({busyE, doneE, errE, parE, brkE, outE} !== 13'h0) begin
      errors++; $display("FAIL rstmid_e: got %h expected 0", {busyE, doneE, errE, parE, brkE, outE});
    end
    @(negedge clk);
    rxA = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expOutA = 8'h00;
    expOutE = 8'h00;
    driveLevel(0, 1'b1, 2 * BIT);
  endtask

  task automatic test_exclusive();
    checks++;
    if (nBoth != 0) begin errors++; $display("FAIL done_err_overlap: got %0d cycles expected 0", nBoth); end
  endtask

  initial begin
    test_reset();
    test_tolerance();
    test_framing();
    test_parity();
    test_glitch();
    test_break();
    test_enable();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
